bias_out_axis_packer: RTL



---
 rtl/bias_out_axis_packer_if.sv | 30 +++
 rtl/bias_out_axis_packer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/bias_out_axis_packer_if.sv
// Handshake bundle between the bias-add vector stream, the AXIS sink and the packer.
// The packer side is the master modport; the environment side is the slave modport.
interface bias_out_axis_packer_if #(
   parameter int TILE_SIZE    = 4,
   parameter int DATA_WIDTH   = 16,
   parameter int VEC_PER_BEAT = 2
);
   localparam int TDATA_W = VEC_PER_BEAT * TILE_SIZE * DATA_WIDTH;

   logic                                         in_valid;
   logic                                         in_ready;
   logic signed [TILE_SIZE-1:0][DATA_WIDTH-1:0]  in_vec;
   logic                                         flush;
   logic                                         m_axis_TVALID;
   logic                                         m_axis_TREADY;
   logic [TDATA_W-1:0]                           m_axis_TDATA;
   logic [TDATA_W/8-1:0]                         m_axis_TKEEP;
   logic                                         m_axis_TLAST;
   logic                                         row_done;

   modport master (
      input  in_valid, in_vec, flush, m_axis_TREADY,
      output in_ready, m_axis_TVALID, m_axis_TDATA, m_axis_TKEEP, m_axis_TLAST, row_done
   );

   modport slave (
      output in_valid, in_vec, flush, m_axis_TREADY,
      input  in_ready, m_axis_TVALID, m_axis_TDATA, m_axis_TKEEP, m_axis_TLAST, row_done
   );
endinterface

// File: rtl/bias_out_axis_packer.sv
// Packs VEC_PER_BEAT bias_out vectors per AXIS beat, buffers beats in a small
// fall-through FIFO and marks the last beat of each D-element row with TLAST.
module bias_out_axis_packer #(
   parameter int TILE_SIZE    = 4,
   parameter int DATA_WIDTH   = 16,
   parameter int D            = 256,
   parameter int VEC_PER_BEAT = 2,
   parameter int FIFO_DEPTH   = 4
) (
   input logic                     clk,
   input logic                     rst_n,
   bias_out_axis_packer_if.master  bus
);
   localparam int VEC_W         = TILE_SIZE * DATA_WIDTH;
   localparam int TDATA_W       = VEC_PER_BEAT * VEC_W;
   localparam int KEEP_W        = TDATA_W / 8;
   localparam int VEC_KEEP      = VEC_W / 8;
   localparam int BEATS_PER_ROW = D / (TILE_SIZE * VEC_PER_BEAT);
   localparam int SLOT_W        = (VEC_PER_BEAT > 1) ? $clog2(VEC_PER_BEAT) : 1;
   localparam int BCNT_W        = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
   localparam int PTR_W         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W         = PTR_W + 1;

   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(VEC_PER_BEAT - 1);
   localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS_PER_ROW - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

   logic [SLOT_W-1:0]                      slot_q, slot_d;
   logic [BCNT_W-1:0]                      bcnt_q, bcnt_d;
   logic [VEC_PER_BEAT-2:0][VEC_W-1:0]     pack_q, pack_d;
   logic                                   pend_q, pend_d;
   logic [PTR_W-1:0]                       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]                       rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]                       cnt_q, cnt_d;
   logic                                   row_done_q, row_done_d;

   logic [TDATA_W-1:0]                     data_mem [FIFO_DEPTH];
   logic [KEEP_W-1:0]                      keep_mem [FIFO_DEPTH];
   logic                                   last_mem [FIFO_DEPTH];

   logic                                   fifo_full, last_slot, in_ready, in_fire;
   logic                                   fifo_valid, pop, flush_exec, push;
   logic [TDATA_W-1:0]                     full_data, part_data, push_data;
   logic [KEEP_W-1:0]                      part_keep, push_keep;
   logic                                   push_last;

   always_comb begin
      fifo_full  = (cnt_q == FULL_CNT);
      last_slot  = (slot_q == LAST_SLOT);
      in_ready   = !pend_q && (!last_slot || !fifo_full);
      in_fire    = bus.in_valid && in_ready;
      fifo_valid = (cnt_q != '0);
      pop        = fifo_valid && bus.m_axis_TREADY;
      flush_exec = pend_q && !fifo_full;
   end

   // Full beat merges the held slots with the live vector; a flushed beat
   // carries only the slots already filled and zeroes the rest.
   always_comb begin
      full_data = '0;
      part_data = '0;
      part_keep = '0;
      for (int s = 0; s < VEC_PER_BEAT - 1; s++) begin
         full_data[s*VEC_W +: VEC_W] = pack_q[s];
         if (SLOT_W'(s) < slot_q) begin
            part_data[s*VEC_W +: VEC_W]      = pack_q[s];
            part_keep[s*VEC_KEEP +: VEC_KEEP] = '1;
         end
      end
      full_data[(VEC_PER_BEAT-1)*VEC_W +: VEC_W] = bus.in_vec;

      push      = (in_fire && last_slot) || (flush_exec && (slot_q != '0));
      push_data = flush_exec ? part_data : full_data;
      push_keep = flush_exec ? part_keep : '1;
      push_last = flush_exec ? 1'b1 : ((bcnt_q == LAST_BEAT) || bus.flush);
   end

   always_comb begin
      slot_d = slot_q;
      bcnt_d = bcnt_q;
      pack_d = pack_q;
      pend_d = pend_q;
      if (in_fire) begin
         if (last_slot) begin
            slot_d = '0;
            bcnt_d = push_last ? '0 : bcnt_q + 1'b1;
         end else begin
            slot_d = slot_q + 1'b1;
            for (int s = 0; s < VEC_PER_BEAT - 1; s++) begin
               if (SLOT_W'(s) == slot_q) pack_d[s] = bus.in_vec;
            end
         end
      end
      // A flush that rides on a beat-completing vector is already satisfied by its TLAST.
      if (flush_exec) begin
         slot_d = '0;
         bcnt_d = '0;
         pend_d = 1'b0;
      end else if (bus.flush && !(in_fire && last_slot)) begin
         pend_d = 1'b1;
      end
   end

   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      cnt_d      = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
      row_done_d = pop && last_mem[rd_ptr_q];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q     <= '0;
         bcnt_q     <= '0;
         pack_q     <= '0;
         pend_q     <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         row_done_q <= 1'b0;
      end else begin
         slot_q     <= slot_d;
         bcnt_q     <= bcnt_d;
         pack_q     <= pack_d;
         pend_q     <= pend_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         row_done_q <= row_done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr_q] <= push_data;
         keep_mem[wr_ptr_q] <= push_keep;
         last_mem[wr_ptr_q] <= push_last;
      end
   end

   // Head outputs are gated so stale storage never shows while the FIFO is empty.
   assign bus.in_ready      = in_ready;
   assign bus.m_axis_TVALID = fifo_valid;
   assign bus.m_axis_TDATA  = fifo_valid ? data_mem[rd_ptr_q] : '0;
   assign bus.m_axis_TKEEP  = fifo_valid ? keep_mem[rd_ptr_q] : '0;
   assign bus.m_axis_TLAST  = fifo_valid ? last_mem[rd_ptr_q] : 1'b0;
   assign bus.row_done      = row_done_q;
endmodule
